// File: rtl/ara_perf_snapshot_regs_if.sv
// APB bus bundle for the perf snapshot register file.
// Signal names match the register block's port names.
interface ara_perf_snapshot_regs_if #(
  parameter int unsigned AddrWidth = 32
);
  logic                 psel_i;
  logic                 penable_i;
  logic                 pwrite_i;
  logic [AddrWidth-1:0] paddr_i;
  logic [31:0]          pwdata_i;
  logic [31:0]          prdata_o;
  logic                 pready_o;
  logic                 pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/ara_perf_snapshot_regs.sv
// APB register file holding 64-bit perf counter snapshots, read as LO/HI halves with
// HI shadowing so a LO-then-HI pair is always consistent.
module ara_perf_snapshot_regs #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned SeqWidth  = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           snap_update_i,
  input  logic [63:0]                    runtime_i,
  input  logic [63:0]                    dcache_stall_i,
  input  logic [63:0]                    icache_stall_i,
  input  logic [63:0]                    sb_full_i,
  output logic                           hw_cnt_en_o,
  ara_perf_snapshot_regs_if.slave        apb
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e r_state, w_state_d;

  logic [63:0]         r_snap   [4];
  logic [31:0]         r_shadow [4];
  logic [SeqWidth-1:0] r_seq;
  logic                r_snap_valid;
  logic                r_overrun;
  logic                r_pending;
  logic                r_cnt_en;

  logic [31:0] r_prdata;
  logic        r_pslverr;

  // Transfer attributes latched on WAIT->RESP, consumed by the RESP commit.
  logic        r_cmt_write;
  logic [3:0]  r_cmt_idx;
  logic [1:0]  r_cmt_sel;
  logic        r_cmt_is_cnt;
  logic [1:0]  r_cmt_wdata;
  logic [31:0] r_hi_cap;

  logic [3:0]  w_idx;
  logic [1:0]  w_cnt_sel;
  logic        w_is_cnt;
  logic        w_err;
  logic [63:0] w_snap_sel;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic        w_commit;
  logic        w_wr_ctrl;
  logic        w_clear;
  logic        w_w1c;
  logic        w_rd_lo;
  logic        w_rd_hi;
  logic        w_unused;

  assign w_unused = ^{apb.paddr_i[AddrWidth-1:6], apb.paddr_i[1:0], apb.pwdata_i[31:2]};

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (apb.psel_i && apb.penable_i) w_state_d = StWait;
      StWait:  w_state_d = StResp;
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_idx = apb.paddr_i[5:2];

  // Offsets 0x08..0x24 map pairwise onto the four counters.
  always_comb begin
    w_is_cnt  = 1'b1;
    w_cnt_sel = 2'd0;
    case (w_idx[3:1])
      3'd1:    w_cnt_sel = 2'd0;
      3'd2:    w_cnt_sel = 2'd1;
      3'd3:    w_cnt_sel = 2'd2;
      3'd4:    w_cnt_sel = 2'd3;
      default: w_is_cnt  = 1'b0;
    endcase
  end

  assign w_err      = (w_idx >= 4'd10) || (apb.pwrite_i && w_is_cnt);
  assign w_snap_sel = r_snap[w_cnt_sel];
  assign w_status   = {16'(r_seq), 14'b0, r_overrun, r_snap_valid};

  always_comb begin
    w_rdata = 32'b0;
    if (!apb.pwrite_i && !w_err) begin
      if (w_idx == 4'd0) begin
        w_rdata = {31'b0, r_cnt_en};
      end else if (w_idx == 4'd1) begin
        w_rdata = w_status;
      end else if (w_is_cnt) begin
        w_rdata = w_idx[0] ? r_shadow[w_cnt_sel] : w_snap_sel[31:0];
      end
    end
  end

  assign w_commit  = (r_state == StResp) && !r_pslverr;
  assign w_wr_ctrl = w_commit && r_cmt_write && (r_cmt_idx == 4'd0);
  assign w_clear   = w_wr_ctrl && r_cmt_wdata[1];
  assign w_w1c     = w_commit && r_cmt_write && (r_cmt_idx == 4'd1) && r_cmt_wdata[1];
  assign w_rd_lo   = w_commit && !r_cmt_write && r_cmt_is_cnt && !r_cmt_idx[0];
  assign w_rd_hi   = w_commit && !r_cmt_write && r_cmt_is_cnt && r_cmt_idx[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_prdata     <= 32'b0;
      r_pslverr    <= 1'b0;
      r_cmt_write  <= 1'b0;
      r_cmt_idx    <= 4'b0;
      r_cmt_sel    <= 2'b0;
      r_cmt_is_cnt <= 1'b0;
      r_cmt_wdata  <= 2'b0;
      r_hi_cap     <= 32'b0;
    end else begin
      r_state      <= w_state_d;
      // Response data lives only in RESP; zero in every other state.
      r_prdata     <= (r_state == StWait) ? w_rdata : 32'b0;
      r_pslverr    <= (r_state == StWait) && w_err;
      if (r_state == StWait) begin
        r_cmt_write  <= apb.pwrite_i;
        r_cmt_idx    <= w_idx;
        r_cmt_sel    <= w_cnt_sel;
        r_cmt_is_cnt <= w_is_cnt;
        r_cmt_wdata  <= apb.pwdata_i[1:0];
        r_hi_cap     <= w_snap_sel[63:32];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        r_snap[i]   <= 64'b0;
        r_shadow[i] <= 32'b0;
      end
      r_seq        <= '0;
      r_snap_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_pending    <= 1'b0;
      r_cnt_en     <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_cnt_en <= r_cmt_wdata[0];
      if (w_clear) begin
        for (int i = 0; i < 4; i++) begin
          r_snap[i]   <= 64'b0;
          r_shadow[i] <= 32'b0;
        end
        r_seq        <= '0;
        r_snap_valid <= 1'b0;
        r_overrun    <= 1'b0;
        r_pending    <= 1'b0;
      end else begin
        if (snap_update_i) begin
          r_snap[0]    <= runtime_i;
          r_snap[1]    <= dcache_stall_i;
          r_snap[2]    <= icache_stall_i;
          r_snap[3]    <= sb_full_i;
          r_snap_valid <= 1'b1;
          r_seq        <= r_seq + SeqWidth'(1);
        end
        // r_hi_cap was sampled with the LO data, so an update landing now cannot tear the pair.
        if (w_rd_lo) r_shadow[r_cmt_sel] <= r_hi_cap;
        if (w_rd_lo) begin
          r_pending <= 1'b1;
        end else if (w_rd_hi) begin
          r_pending <= 1'b0;
        end
        if (snap_update_i && (r_pending || w_rd_lo)) begin
          r_overrun <= 1'b1;
        end else if (w_w1c) begin
          r_overrun <= 1'b0;
        end
      end
    end
  end

  assign hw_cnt_en_o   = r_cnt_en;
  assign apb.prdata_o  = r_prdata;
  assign apb.pslverr_o = r_pslverr;
  assign apb.pready_o  = (r_state == StResp);

endmodule

// File: tb/tb_ara_perf_snapshot_regs.sv
// Directed bench for ara_perf_snapshot_regs: vector table plus hand sequences for
// overrun, same-cycle update/read, clear-vs-update, mid-transfer reset and seq wrap.
module tb_ara_perf_snapshot_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        snap;
  logic [63:0] rt, dc, ic, sb;
  logic        cnt_en;

  always #5 clk = ~clk;

  ara_perf_snapshot_regs_if #(.AddrWidth(32)) bus ();

  ara_perf_snapshot_regs #(
    .AddrWidth(32),
    .SeqWidth (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .snap_update_i (snap),
    .runtime_i     (rt),
    .dcache_stall_i(dc),
    .icache_stall_i(ic),
    .sb_full_i     (sb),
    .hw_cnt_en_o   (cnt_en),
    .apb           (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // One APB transfer; returns at the falling edge inside the RESP cycle.
  // pulse=1 raises snap_update_i for exactly the RESP (commit) cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic pulse, output logic [31:0] rd, output logic err,
                      output int lat);
    @(negedge clk);
    bus.psel_i    = 1'b1;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = wr;
    bus.paddr_i   = addr;
    bus.pwdata_i  = wd;
    @(negedge clk);
    bus.penable_i = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.pready_o !== 1'b1 && lat < 20);
    rd  = bus.prdata_o;
    err = bus.pslverr_o;
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = 1'b0;
    if (pulse) begin
      snap = 1'b1;
      @(negedge clk);
      snap = 1'b0;
    end
  endtask

  task automatic access(input string name, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input logic pulse);
    logic [31:0] rd;
    logic        err;
    int          lat;
    xfer(wr, addr, wd, pulse, rd, err, lat);
    chk({name, " prdata"}, rd, exp_rd);
    chk({name, " pslverr"}, {31'b0, err}, {31'b0, exp_err});
    chk({name, " latency"}, 32'(lat), 32'd2);
  endtask

  task automatic pulse_snap();
    @(negedge clk);
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
  endtask

  task automatic set_inputs();
    rt = 64'h0000_0012_3456_789A;
    dc = 64'h1111_2222_3333_4444;
    ic = 64'hAAAA_BBBB_CCCC_DDDD;
    sb = 64'h0000_0001_0000_0002;
  endtask

  initial begin
    rst = 1'b1;
    snap = 1'b0;
    rt = '0; dc = '0; ic = '0; sb = '0;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
    bus.paddr_i = '0; bus.pwdata_i = '0;

    // Vector table: applied after one snapshot of set_inputs() values.
    tbl[0]  = '{1'b0, 32'h0C, 32'h0, 32'h0000_0000, 1'b0};  // HI before any LO: stale 0
    tbl[1]  = '{1'b0, 32'h08, 32'h0, 32'h3456_789A, 1'b0};
    tbl[2]  = '{1'b0, 32'h0C, 32'h0, 32'h0000_0012, 1'b0};
    tbl[3]  = '{1'b0, 32'h04, 32'h0, 32'h0001_0001, 1'b0};
    tbl[4]  = '{1'b0, 32'h18, 32'h0, 32'hCCCC_DDDD, 1'b0};
    tbl[5]  = '{1'b0, 32'h1C, 32'h0, 32'hAAAA_BBBB, 1'b0};
    tbl[6]  = '{1'b0, 32'h20, 32'h0, 32'h0000_0002, 1'b0};
    tbl[7]  = '{1'b0, 32'h24, 32'h0, 32'h0000_0001, 1'b0};
    tbl[8]  = '{1'b0, 32'h00, 32'h0, 32'h0000_0001, 1'b0};
    tbl[9]  = '{1'b1, 32'h04, 32'hFFFF_FFFF, 32'h0, 1'b0};
    tbl[10] = '{1'b0, 32'h04, 32'h0, 32'h0001_0001, 1'b0};
    tbl[11] = '{1'b0, 32'h28, 32'h0, 32'h0, 1'b1};
    tbl[12] = '{1'b0, 32'h3C, 32'h0, 32'h0, 1'b1};
    tbl[13] = '{1'b1, 32'h08, 32'hDEAD, 32'h0, 1'b1};
    tbl[14] = '{1'b1, 32'h24, 32'h1, 32'h0, 1'b1};
    tbl[15] = '{1'b0, 32'h48, 32'h0, 32'h3456_789A, 1'b0};  // aliases 0x08
    tbl[16] = '{1'b0, 32'h0C, 32'h0, 32'h0000_0012, 1'b0};
    tbl[17] = '{1'b0, 32'h10, 32'h0, 32'h3333_4444, 1'b0};
    tbl[18] = '{1'b0, 32'h14, 32'h0, 32'h1111_2222, 1'b0};
    tbl[19] = '{1'b0, 32'h00, 32'h0, 32'h0000_0001, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset pready", {31'b0, bus.pready_o}, 32'd0);
    chk("reset prdata", bus.prdata_o, 32'd0);
    chk("reset pslverr", {31'b0, bus.pslverr_o}, 32'd0);
    chk("reset cnt_en", {31'b0, cnt_en}, 32'd0);
    access("reset status", 1'b0, 32'h04, 32'h0, 32'h0, 1'b0, 1'b0);

    // cnt_en write: still 0 during RESP, 1 one cycle later.
    access("ctrl write", 1'b1, 32'h00, 32'h1, 32'h0, 1'b0, 1'b0);
    chk("cnt_en in resp", {31'b0, cnt_en}, 32'd0);
    @(negedge clk);
    chk("cnt_en after resp", {31'b0, cnt_en}, 32'd1);
    access("ctrl read", 1'b0, 32'h00, 32'h0, 32'h1, 1'b0, 1'b0);

    set_inputs();
    pulse_snap();
    rt = 64'hDEAD_BEEF_DEAD_BEEF; dc = '1; ic = '1; sb = '1;
    for (int i = 0; i < 20; i++) begin
      access($sformatf("vec[%0d]", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata,
             tbl[i].exp_rd, tbl[i].exp_err, 1'b0);
    end

    // Update between LO and HI reads: HI keeps the old half, overrun sticks until W1C.
    set_inputs();
    access("ovr lo", 1'b0, 32'h10, 32'h0, 32'h3333_4444, 1'b0, 1'b0);
    dc = 64'hFFFF_FFFF_0000_0001;
    pulse_snap();
    access("ovr hi", 1'b0, 32'h14, 32'h0, 32'h1111_2222, 1'b0, 1'b0);
    access("ovr status", 1'b0, 32'h04, 32'h0, 32'h0002_0003, 1'b0, 1'b0);
    access("ovr w1c", 1'b1, 32'h04, 32'h2, 32'h0, 1'b0, 1'b0);
    access("ovr status2", 1'b0, 32'h04, 32'h0, 32'h0002_0001, 1'b0, 1'b0);
    access("new dc lo", 1'b0, 32'h10, 32'h0, 32'h0000_0001, 1'b0, 1'b0);
    access("new dc hi", 1'b0, 32'h14, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Update in the same cycle as a LO read commit.
    ic = 64'h5555_6666_7777_8888;
    access("same lo", 1'b0, 32'h18, 32'h0, 32'hCCCC_DDDD, 1'b0, 1'b1);
    access("same hi", 1'b0, 32'h1C, 32'h0, 32'hAAAA_BBBB, 1'b0, 1'b0);
    access("same status", 1'b0, 32'h04, 32'h0, 32'h0003_0003, 1'b0, 1'b0);
    access("post lo", 1'b0, 32'h18, 32'h0, 32'h7777_8888, 1'b0, 1'b0);
    access("post hi", 1'b0, 32'h1C, 32'h0, 32'h5555_6666, 1'b0, 1'b0);

    // Clear committed together with an update: clear wins, cnt_en stays 1.
    access("clear write", 1'b1, 32'h00, 32'h3, 32'h0, 1'b0, 1'b1);
    chk("clear cnt_en", {31'b0, cnt_en}, 32'd1);
    access("clr shadow", 1'b0, 32'h1C, 32'h0, 32'h0, 1'b0, 1'b0);
    access("clr status", 1'b0, 32'h04, 32'h0, 32'h0, 1'b0, 1'b0);
    access("clr rt lo", 1'b0, 32'h08, 32'h0, 32'h0, 1'b0, 1'b0);
    access("clr rt hi", 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0, 1'b0);
    access("clr ic lo", 1'b0, 32'h18, 32'h0, 32'h0, 1'b0, 1'b0);
    access("clr sb hi", 1'b0, 32'h24, 32'h0, 32'h0, 1'b0, 1'b0);
    access("clr ctrl", 1'b0, 32'h00, 32'h0, 32'h1, 1'b0, 1'b0);

    // Reset during the WAIT cycle aborts the transfer.
    @(negedge clk);
    bus.psel_i = 1'b1; bus.pwrite_i = 1'b1; bus.paddr_i = 32'h00; bus.pwdata_i = 32'h1;
    @(negedge clk);
    bus.penable_i = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort pready", {31'b0, bus.pready_o}, 32'd0);
    chk("abort cnt_en", {31'b0, cnt_en}, 32'd0);
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("abort pready2", {31'b0, bus.pready_o}, 32'd0);
    @(negedge clk);
    chk("abort cnt_en2", {31'b0, cnt_en}, 32'd0);
    access("abort status", 1'b0, 32'h04, 32'h0, 32'h0, 1'b0, 1'b0);

    // 65536 updates from reset: seq wraps to 0, snap_valid stays set.
    @(negedge clk);
    snap = 1'b1;
    repeat (65535) @(negedge clk);
    snap = 1'b0;
    access("seq ffff", 1'b0, 32'h04, 32'h0, 32'hFFFF_0001, 1'b0, 1'b0);
    pulse_snap();
    access("seq wrap", 1'b0, 32'h04, 32'h0, 32'h0000_0001, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
